uart_rx: RTL

- Serial-to-parallel UART receiver, 8N1 framing, LSB first.
- Sits between the `rx` pad and the write side of the receive FIFO: `rx_data`/`rx_valid` connect to the FIFO's data/wrreq, and `fifo_full` connects to wrfull.
- Runs entirely on `core_clock`; bit timing comes from an internal divisor counter, not a separate UART clock.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a FIFO write port; bit timing from a core-clock divisor.
// Reset is asserted asynchronously and released synchronously through a local two-flop stage.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       core_clock,
  input  logic       core_reset_n,
  input  logic       rx,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TICK_V = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_V = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             sh_q, sh_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   tick, half;

  always_ff @(posedge core_clock or negedge core_reset_n) begin
    if (!core_reset_n) rst_sync_q <= 2'b00;
    else               rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign tick   = (cnt_q == TICK_V);
  assign half   = (cnt_q == HALF_V);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    oe_d    = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) state_d = START;
      START: if (half) begin
        if (!rx_s) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (tick) begin
        sh_d  = {rx_s, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        if (rx_s) begin
          // fifo_full only matters here, at the stop-bit sample
          if (fifo_full) oe_d = 1'b1;
          else begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge core_clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;
  assign busy          = busy_q;
endmodule
